gb_bus_master: RTL and testbench



---
 rtl/gb_bus_master.sv | 152 +++++++++++++++
 tb/tb_gb_bus_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gb_bus_master.sv
// Game Boy cartridge bus initiator: turns single-byte ready/valid requests into
// SETUP/STROBE/HOLD read or write cycles. Optional GB_BUS_MASTER_TURNAROUND_EN adds an idle cycle after reads.
module gb_bus_master #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req,
  output logic        ready,
  input  logic        req_we,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        done,
  output logic [14:0] adr,
  output logic        a15,
  output logic        n_read,
  output logic        n_write,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [7:0] SETUP_LD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LD = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(T_HOLD - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic [14:0] adr_q, adr_d;
  logic        a15_q, a15_d;
  logic        n_read_q, n_read_d;
  logic        n_write_q, n_write_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        accept;
  logic        capture;

  assign accept = (state_q == IDLE) && ready_q && req;

  // Phase counter is loaded with (length-1) on state entry and counts down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every pad-facing signal is a flop.
  always_comb begin
    capture    = (state_q == STROBE) && (state_d == HOLD) && !we_q;
    we_d       = accept ? req_we : we_q;
    adr_d      = accept ? req_adr[14:0] : adr_q;
    a15_d      = (state_d == IDLE) ? 1'b1 : (accept ? req_adr[15] : a15_q);
    data_out_d = (accept && req_we) ? req_wdata : data_out_q;
    data_oe_d  = (state_d != IDLE) && we_d;
    n_read_d   = !((state_d == STROBE) && !we_d);
    n_write_d  = !((state_d == STROBE) && we_d);
    rvalid_d   = capture;
    rdata_d    = capture ? data_in : rdata_q;
    done_d     = (state_d == HOLD) && (cnt_d == 8'd0);
`ifdef GB_BUS_MASTER_TURNAROUND_EN
    ready_d    = (state_d == IDLE) && !((state_q == HOLD) && !we_q);
`else
    ready_d    = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      we_q       <= 1'b0;
      ready_q    <= 1'b1;
      rdata_q    <= 8'd0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      adr_q      <= 15'd0;
      a15_q      <= 1'b1;
      n_read_q   <= 1'b1;
      n_write_q  <= 1'b1;
      data_out_q <= 8'd0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      adr_q      <= adr_d;
      a15_q      <= a15_d;
      n_read_q   <= n_read_d;
      n_write_q  <= n_write_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;
  assign adr      = adr_q;
  assign a15      = a15_q;
  assign n_read   = n_read_q;
  assign n_write  = n_write_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_gb_bus_master.sv
// Bench for gb_bus_master: timeline reference model of a transaction, directed
// cartridge cycles, mid-transaction reset, short-timing instance and 1000 random requests.
module tb_gb_bus_master;

  localparam int TS  = 2;
  localparam int TST = 4;
  localparam int TH  = 2;
  localparam int TOT = TS + TST + TH;
`ifdef GB_BUS_MASTER_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  // default-timing instance
  logic        req, req_we, ready, rvalid, done, a15, n_read, n_write, data_oe;
  logic [15:0] req_adr;
  logic [7:0]  req_wdata, rdata, data_out, data_in;
  logic [14:0] adr;

  gb_bus_master dut (
    .clk(clk), .n_reset(n_reset), .req(req), .ready(ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata), .rdata(rdata), .rvalid(rvalid),
    .done(done), .adr(adr), .a15(a15), .n_read(n_read), .n_write(n_write),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  // shortest-timing instance
  logic        f_req, f_req_we, f_ready, f_rvalid, f_done, f_a15, f_n_read, f_n_write, f_data_oe;
  logic [15:0] f_req_adr;
  logic [7:0]  f_req_wdata, f_rdata, f_data_out, f_data_in;
  logic [14:0] f_adr;

  gb_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_fast (
    .clk(clk), .n_reset(n_reset), .req(f_req), .ready(f_ready), .req_we(f_req_we),
    .req_adr(f_req_adr), .req_wdata(f_req_wdata), .rdata(f_rdata), .rvalid(f_rvalid),
    .done(f_done), .adr(f_adr), .a15(f_a15), .n_read(f_n_read), .n_write(f_n_write),
    .data_out(f_data_out), .data_oe(f_data_oe), .data_in(f_data_in)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: a transaction is a timeline indexed by cycles since acceptance
  logic        m_busy, m_we, m_post_read;
  int          m_age, m_idle_age, n_acc;
  logic [15:0] m_adr;
  logic [7:0]  m_wdata, m_rd, m_rdata;

  task automatic model_reset();
    m_busy = 1'b0; m_we = 1'b0; m_post_read = 1'b0;
    m_age = 0; m_idle_age = 0;
    m_adr = 16'd0; m_wdata = 8'd0; m_rd = 8'd0; m_rdata = 8'd0;
    exp_q.delete();
  endtask

  function automatic logic model_ready();
    return !m_busy && !(TURN && m_post_read && m_idle_age == 0);
  endfunction

  task automatic compare_cycle();
    logic strobe, rv;
    strobe = m_busy && m_age >= TS && m_age < TS + TST;
    rv     = m_busy && !m_we && m_age == TS + TST;
    if (rv && exp_q.size() > 0) m_rdata = exp_q.pop_front();
    check("ready",   ready,   model_ready());
    check("n_read",  n_read,  !(strobe && !m_we));
    check("n_write", n_write, !(strobe && m_we));
    check("a15",     a15,     m_busy ? m_adr[15] : 1'b1);
    check("adr",     adr,     m_adr[14:0]);
    check("data_oe", data_oe, m_busy && m_we);
    if (m_busy && m_we) check("data_out", data_out, m_wdata);
    check("rvalid",  rvalid,  rv);
    check("rdata",   rdata,   m_rdata);
    check("done",    done,    m_busy && m_age == TOT - 1);
  endtask

  // driver: called at a negedge, applies one cycle of request inputs
  task automatic step(input logic r, input logic we, input logic [15:0] a,
                      input logic [7:0] wd, input logic [7:0] rd);
    logic acc;
    req = r; req_we = we; req_adr = a; req_wdata = wd;
    acc = r && model_ready();
    @(posedge clk);
    if (m_busy) begin
      m_age++;
      if (m_age == TOT) begin
        m_busy = 1'b0; m_idle_age = 0; m_post_read = !m_we;
      end
    end else if (acc) begin
      m_busy = 1'b1; m_age = 0; m_we = we; m_adr = a; n_acc++;
      if (we) m_wdata = wd;
      else begin
        m_rd = rd;
        exp_q.push_back(rd);
      end
    end else begin
      m_idle_age++;
    end
    @(negedge clk);
    data_in = (!n_read) ? m_rd : 8'($urandom);
    compare_cycle();
  endtask

  // protocol monitor
  logic [15:0] mon_adr;
  logic        mon_low = 1'b0;
  always @(negedge clk) begin
    if (n_reset) begin
      check("excl_strobe", n_read | n_write, 1'b1);
      if ((!n_read || !n_write) && mon_low) check("adr_stable", {a15, adr}, mon_adr);
    end
    mon_low = !n_read || !n_write;
    mon_adr = {a15, adr};
  end

  initial begin
    int start_acc;
    n_reset = 1'b0;
    req = 1'b0; req_we = 1'b0; req_adr = 16'd0; req_wdata = 8'd0; data_in = 8'd0;
    f_req = 1'b0; f_req_we = 1'b0; f_req_adr = 16'd0; f_req_wdata = 8'd0; f_data_in = 8'd0;
    n_acc = 0;
    model_reset();
    @(negedge clk);
    compare_cycle();
    @(negedge clk);
    n_reset = 1'b1;
    compare_cycle();

    // read 0x0148, cartridge answers 0x05
    step(1'b1, 1'b0, 16'h0148, 8'h00, 8'h05);
    repeat (TOT + 1) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    check("rd_0148_rdata", rdata, 8'h05);

    // write 0x0A to 0x0000
    step(1'b1, 1'b1, 16'h0000, 8'h0A, 8'h00);
    repeat (TOT + 1) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

    // write 0xA000 then req held with a read of 0xA000, then read-then-write held
    step(1'b1, 1'b1, 16'hA000, 8'h12, 8'h00);
    repeat (TOT + 2) step(1'b1, 1'b0, 16'hA000, 8'h00, 8'h9E);
    repeat (TOT + 3) step(1'b1, 1'b1, 16'hA001, 8'h34, 8'h00);
    repeat (TOT + 2) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

    // reset asserted mid-STROBE of a write
    step(1'b1, 1'b1, 16'h2345, 8'hC3, 8'h00);
    repeat (TS + 1) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    check("pre_rst_n_write", n_write, 1'b0);
    #2 n_reset = 1'b0;
    #1;
    check("rst_n_write", n_write, 1'b1);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_ready",   ready,   1'b1);
    check("rst_a15",     a15,     1'b1);
    check("rst_adr",     adr,     15'd0);
    check("rst_done",    done,    1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    compare_cycle();
    repeat (TOT + 2) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);

    // shortest timing: read of 0x1234
    check("f_ready0", f_ready, 1'b1);
    f_req = 1'b1; f_req_we = 1'b0; f_req_adr = 16'h1234; f_data_in = 8'hEE;
    @(negedge clk);
    f_req = 1'b0;
    check("f_setup_n_read", f_n_read, 1'b1);
    check("f_setup_adr", {f_a15, f_adr}, 16'h1234);
    check("f_setup_ready", f_ready, 1'b0);
    @(negedge clk);
    check("f_strobe_n_read", f_n_read, 1'b0);
    check("f_strobe_oe", f_data_oe, 1'b0);
    f_data_in = 8'h3C;
    @(negedge clk);
    f_data_in = 8'hEE;
    check("f_rvalid", f_rvalid, 1'b1);
    check("f_rdata", f_rdata, 8'h3C);
    check("f_done", f_done, 1'b1);
    check("f_hold_n_read", f_n_read, 1'b1);
    @(negedge clk);
    check("f_idle_ready", f_ready, 1'b1);
    check("f_idle_rvalid", f_rvalid, 1'b0);
    check("f_idle_done", f_done, 1'b0);
    check("f_idle_a15", f_a15, 1'b1);

    // 1000 random requests
    start_acc = n_acc;
    for (int c = 0; c < 30000 && (n_acc - start_acc) < 1000; c++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
           8'($urandom), 8'($urandom));
    check("rand_count", n_acc - start_acc, 1000);
    repeat (TOT + 2) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
